// File: rtl/rep_seq_pkg.sv
// Shared encodings and the operand-size step helper for the x86 string-op
// iteration sequencer.
package rep_seq_pkg;

  typedef enum logic [1:0] {
    REP_NONE = 2'b00,
    REP_E    = 2'b01,
    REP_NE   = 2'b10
  } rep_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_SKIP = 2'b10
  } state_e;

  // Opsize 11 is treated as dword.
  function automatic logic [2:0] op_step(input logic [1:0] opsize);
    logic [2:0] step;
    case (opsize)
      2'b00:   step = 3'd1;
      2'b01:   step = 3'd2;
      default: step = 3'd4;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/rep_addr_step.sv
// Next-address computation for one string pointer (ESI or EDI).
// Wraps modulo 2^ADDR_W in either direction.
module rep_addr_step
  import rep_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] cur,
  input  logic [1:0]        opsize,
  input  logic              df,
  output logic [ADDR_W-1:0] nxt
);

  logic [ADDR_W-1:0] w_step;

  assign w_step = {{(ADDR_W-3){1'b0}}, op_step(opsize)};

  // Increment or decrement by the element size.
  always_comb begin
    nxt = cur;
    if (df) begin
      nxt = cur - w_step;
    end else begin
      nxt = cur + w_step;
    end
  end

endmodule

// File: rtl/rep_string_sequencer.sv
// Iteration controller for MOVS/STOS/LODS/CMPS/SCAS with optional REP prefix:
// accepts one decoded instruction and emits one ALU/writeback beat per iteration.
module rep_string_sequencer
  import rep_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rep,
  input  logic              in_cmp,
  input  logic [1:0]        in_opsize,
  input  logic              in_df,
  input  logic [CNT_W-1:0]  in_ecx,
  input  logic [ADDR_W-1:0] in_esi,
  input  logic [ADDR_W-1:0] in_edi,
  output logic              it_valid,
  input  logic              it_ready,
  output logic [ADDR_W-1:0] it_esi,
  output logic [ADDR_W-1:0] it_edi,
  output logic [ADDR_W-1:0] it_esi_next,
  output logic [ADDR_W-1:0] it_edi_next,
  output logic [CNT_W-1:0]  it_ecx,
  output logic              it_skip,
  input  logic              it_zf,
  output logic              it_last,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_esi;
  logic [ADDR_W-1:0] r_edi;
  logic [CNT_W-1:0]  r_ecx;
  logic [1:0]        r_opsize;
  logic              r_df;
  rep_e              r_rep;
  logic              r_cmp;

  rep_e              w_in_rep;
  logic              w_accept;
  logic              w_beat_done;
  logic              w_cnt_last;
  logic              w_zf_stop;
  logic [ADDR_W-1:0] w_esi_step;
  logic [ADDR_W-1:0] w_edi_step;
  logic [CNT_W-1:0]  w_ecx_after;

  rep_addr_step #(.ADDR_W(ADDR_W)) u_esi_step (
    .cur(r_esi), .opsize(r_opsize), .df(r_df), .nxt(w_esi_step)
  );

  rep_addr_step #(.ADDR_W(ADDR_W)) u_edi_step (
    .cur(r_edi), .opsize(r_opsize), .df(r_df), .nxt(w_edi_step)
  );

  // The reserved prefix encoding behaves as no prefix.
  assign w_in_rep    = (in_rep == 2'b11) ? REP_NONE : rep_e'(in_rep);
  assign in_ready    = (r_state == ST_IDLE) & ~flush;
  assign w_accept    = in_valid & in_ready;
  assign w_beat_done = it_valid & it_ready;
  assign busy        = (r_state != ST_IDLE);
  assign it_valid    = (r_state == ST_RUN) | (r_state == ST_SKIP);
  assign it_skip     = (r_state == ST_SKIP);
  assign it_esi      = r_esi;
  assign it_edi      = r_edi;

  assign w_ecx_after = (r_rep != REP_NONE) ? (r_ecx - CNT_ONE) : r_ecx;
  assign w_cnt_last  = (r_rep == REP_NONE) | (r_ecx == CNT_ONE);
  assign w_zf_stop   = r_cmp & (((r_rep == REP_E) & ~it_zf) | ((r_rep == REP_NE) & it_zf));

  // Beat outputs: a SKIP beat leaves pointers and counter untouched.
  always_comb begin
    it_esi_next = r_esi;
    it_edi_next = r_edi;
    it_ecx      = CNT_ZERO;
    it_last     = 1'b0;
    case (r_state)
      ST_RUN: begin
        it_esi_next = w_esi_step;
        it_edi_next = w_edi_step;
        it_ecx      = w_ecx_after;
        it_last     = w_cnt_last | w_zf_stop;
      end
      ST_SKIP: begin
        it_last = 1'b1;
      end
      default: begin
        it_last = 1'b0;
      end
    endcase
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_state_nxt = ((w_in_rep != REP_NONE) && (in_ecx == CNT_ZERO)) ? ST_SKIP : ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_beat_done && it_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_SKIP: begin
          if (w_beat_done) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SKIP;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Holding registers: loaded on accept, advanced on each completed RUN beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_esi    <= {ADDR_W{1'b0}};
      r_edi    <= {ADDR_W{1'b0}};
      r_ecx    <= CNT_ZERO;
      r_opsize <= 2'b00;
      r_df     <= 1'b0;
      r_rep    <= REP_NONE;
      r_cmp    <= 1'b0;
    end else if (w_accept) begin
      r_esi    <= in_esi;
      r_edi    <= in_edi;
      r_ecx    <= in_ecx;
      r_opsize <= in_opsize;
      r_df     <= in_df;
      r_rep    <= w_in_rep;
      r_cmp    <= in_cmp;
    end else if ((r_state == ST_RUN) && w_beat_done && !flush) begin
      r_esi <= w_esi_step;
      r_edi <= w_edi_step;
      r_ecx <= w_ecx_after;
    end
  end

endmodule

// File: tb/tb_rep_string_sequencer.sv
// Directed self-checking bench for rep_string_sequencer.
module tb_rep_string_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_rep = 2'b00;
  logic        in_cmp = 1'b0;
  logic [1:0]  in_opsize = 2'b00;
  logic        in_df = 1'b0;
  logic [31:0] in_ecx = 32'd0;
  logic [31:0] in_esi = 32'd0;
  logic [31:0] in_edi = 32'd0;
  logic        it_valid;
  logic        it_ready = 1'b1;
  logic [31:0] it_esi, it_edi, it_esi_next, it_edi_next, it_ecx;
  logic        it_skip;
  logic        it_zf = 1'b0;
  logic        it_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rep_string_sequencer #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rep(in_rep), .in_cmp(in_cmp),
    .in_opsize(in_opsize), .in_df(in_df), .in_ecx(in_ecx), .in_esi(in_esi), .in_edi(in_edi),
    .it_valid(it_valid), .it_ready(it_ready), .it_esi(it_esi), .it_edi(it_edi),
    .it_esi_next(it_esi_next), .it_edi_next(it_edi_next), .it_ecx(it_ecx),
    .it_skip(it_skip), .it_zf(it_zf), .it_last(it_last), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] rep, input logic cmp, input logic [1:0] opsize,
                       input logic df, input logic [31:0] ecx, input logic [31:0] esi,
                       input logic [31:0] edi);
    in_rep = rep; in_cmp = cmp; in_opsize = opsize; in_df = df;
    in_ecx = ecx; in_esi = esi; in_edi = edi; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] esi, input logic [31:0] esi_nxt,
                      input logic [31:0] ecx, input logic last, input logic zf);
    it_zf = zf;
    #1;
    chk({tag, ".valid"}, {31'd0, it_valid}, 32'd1);
    chk({tag, ".esi"}, it_esi, esi);
    chk({tag, ".esi_next"}, it_esi_next, esi_nxt);
    chk({tag, ".ecx"}, it_ecx, ecx);
    chk({tag, ".last"}, {31'd0, it_last}, {31'd0, last});
    cyc();
  endtask

  initial begin
    #2;
    chk("rst.valid", {31'd0, it_valid}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.skip", {31'd0, it_skip}, 32'd0);
    chk("rst.esi", it_esi, 32'd0);
    chk("rst.ecx", it_ecx, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // Non-REP MOVSD: single beat, ECX untouched.
    issue(2'b00, 1'b0, 2'b10, 1'b0, 32'd5, 32'h100, 32'h200);
    #1;
    chk("movsd.edi_next", it_edi_next, 32'h204);
    chk("movsd.edi", it_edi, 32'h200);
    beat("movsd", 32'h100, 32'h104, 32'd5, 1'b1, 1'b0);
    #1;
    chk("movsd.idle_valid", {31'd0, it_valid}, 32'd0);
    chk("movsd.idle_ready", {31'd0, in_ready}, 32'd1);

    // REP MOVSB ecx=3.
    issue(2'b01, 1'b0, 2'b00, 1'b0, 32'd3, 32'h10, 32'h20);
    beat("repb1", 32'h10, 32'h11, 32'd2, 1'b0, 1'b0);
    beat("repb2", 32'h11, 32'h12, 32'd1, 1'b0, 1'b0);
    beat("repb3", 32'h12, 32'h13, 32'd0, 1'b1, 1'b0);
    #1;
    chk("repb.idle_busy", {31'd0, busy}, 32'd0);

    // REP STOSW ecx=0: one no-op beat.
    issue(2'b01, 1'b0, 2'b01, 1'b0, 32'd0, 32'h40, 32'h80);
    #1;
    chk("skip.flag", {31'd0, it_skip}, 32'd1);
    chk("skip.edi_next", it_edi_next, 32'h80);
    beat("skip", 32'h40, 32'h40, 32'd0, 1'b1, 1'b0);
    #1;
    chk("skip.in_ready", {31'd0, in_ready}, 32'd1);
    chk("skip.after_valid", {31'd0, it_valid}, 32'd0);

    // REPE CMPSW df=1: ZF=1 continues, ZF=0 stops.
    issue(2'b01, 1'b1, 2'b01, 1'b1, 32'd4, 32'h100, 32'h300);
    beat("cmps1", 32'h100, 32'hFE, 32'd3, 1'b0, 1'b1);
    beat("cmps2", 32'hFE, 32'hFC, 32'd2, 1'b1, 1'b0);
    it_zf = 1'b0;
    #1;
    chk("cmps.idle_busy", {31'd0, busy}, 32'd0);

    // REPNE SCASB: ZF=1 stops immediately.
    issue(2'b10, 1'b1, 2'b00, 1'b0, 32'd6, 32'h7, 32'h9);
    beat("scas1", 32'h7, 32'h8, 32'd5, 1'b1, 1'b1);
    it_zf = 1'b0;

    // REP MOVSB ecx=4 with a 3-cycle stall on beat 2.
    issue(2'b01, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 32'h0);
    beat("stl1", 32'h0, 32'h1, 32'd3, 1'b0, 1'b0);
    it_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.esi", it_esi, 32'h1);
      chk("stall.ecx", it_ecx, 32'd2);
      chk("stall.valid", {31'd0, it_valid}, 32'd1);
      cyc();
    end
    it_ready = 1'b1;
    beat("stl2", 32'h1, 32'h2, 32'd2, 1'b0, 1'b0);
    beat("stl3", 32'h2, 32'h3, 32'd1, 1'b0, 1'b0);
    beat("stl4", 32'h3, 32'h4, 32'd0, 1'b1, 1'b0);
    #1;
    chk("stall.idle_busy", {31'd0, busy}, 32'd0);

    // REP ecx=8, flush on beat 3.
    issue(2'b01, 1'b0, 2'b00, 1'b0, 32'd8, 32'h500, 32'h600);
    beat("fl1", 32'h500, 32'h501, 32'd7, 1'b0, 1'b0);
    beat("fl2", 32'h501, 32'h502, 32'd6, 1'b0, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush.valid", {31'd0, it_valid}, 32'd0);
    chk("flush.busy", {31'd0, busy}, 32'd0);
    chk("flush.esi_held", it_esi, 32'h502);

    // Flush in IDLE blocks acceptance.
    in_rep = 2'b00; in_ecx = 32'd1; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle.in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle.busy", {31'd0, busy}, 32'd0);

    // Address wrap going down, and reserved prefix acting as none.
    issue(2'b00, 1'b0, 2'b11, 1'b1, 32'd9, 32'h0, 32'h4);
    #1;
    chk("wrap.edi_next", it_edi_next, 32'h0);
    beat("wrap", 32'h0, 32'hFFFF_FFFC, 32'd9, 1'b1, 1'b0);
    issue(2'b11, 1'b0, 2'b00, 1'b0, 32'd0, 32'h20, 32'h30);
    #1;
    chk("rsvd.skip", {31'd0, it_skip}, 32'd0);
    beat("rsvd", 32'h20, 32'h21, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-RUN.
    issue(2'b01, 1'b0, 2'b00, 1'b0, 32'd8, 32'h900, 32'hA00);
    #1;
    chk("arst.pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst.valid", {31'd0, it_valid}, 32'd0);
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.esi", it_esi, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("arst.in_ready", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
